// File: rtl/vram_pkg.sv
// Tile code constants, style encoding and the kind/style -> tile code mapping
// shared by the VRAM write side and the read-side tile decoder.
package vram_pkg;

  localparam logic [7:0] TILE_I          = 8'd0;
  localparam logic [7:0] TILE_T          = 8'd1;
  localparam logic [7:0] TILE_O          = 8'd2;
  localparam logic [7:0] TILE_J          = 8'd3;
  localparam logic [7:0] TILE_L          = 8'd4;
  localparam logic [7:0] TILE_S          = 8'd5;
  localparam logic [7:0] TILE_Z          = 8'd6;
  localparam logic [7:0] TILE_SHADOW     = 8'd7;
  localparam logic [7:0] TILE_GARBAGE    = 8'd8;
  localparam logic [7:0] TILE_BG         = 8'd9;
  localparam logic [7:0] TILE_DARK_BG    = 8'd10;
  localparam logic [7:0] TILE_LIGHT_BASE = 8'd11;
  localparam logic [7:0] TILE_HALF_BASE  = 8'd18;

  typedef enum logic [1:0] {
    STYLE_SOLID = 2'd0,
    STYLE_LIGHT = 2'd1,
    STYLE_HALF  = 2'd2,
    STYLE_BLANK = 2'd3
  } style_e;

  // Kind 7 is the "special" cell: shadow when solid, garbage when light, dark bg when half.
  function automatic logic [7:0] encode_tile(input logic [2:0] kind, input style_e style);
    logic [7:0] piece;
    logic [7:0] code;
    case (kind)
      3'd0:    piece = TILE_I;
      3'd1:    piece = TILE_T;
      3'd2:    piece = TILE_O;
      3'd3:    piece = TILE_J;
      3'd4:    piece = TILE_L;
      3'd5:    piece = TILE_S;
      3'd6:    piece = TILE_Z;
      default: piece = TILE_SHADOW;
    endcase
    case (style)
      STYLE_SOLID: code = piece;
      STYLE_LIGHT: code = (kind == 3'd7) ? TILE_GARBAGE : TILE_LIGHT_BASE + piece;
      STYLE_HALF:  code = (kind == 3'd7) ? TILE_DARK_BG : TILE_HALF_BASE + piece;
      default:     code = TILE_BG;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/vram_req_fifo.sv
// Synchronous request FIFO holding {addr, code} entries; push and pop may
// coincide at any occupancy, including full.
module vram_req_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vram_tile_writer.sv
// Tile VRAM write side: encodes cell updates, buffers them, and runs full-board
// clear sweeps. Define VRAM_TILE_WRITER_STATS_EN to add the write_count port.
module vram_tile_writer
  import vram_pkg::*;
#(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_x,
  input  logic [4:0]        req_y,
  input  logic [2:0]        req_kind,
  input  logic [1:0]        req_style,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              err_oob,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_data
`ifdef VRAM_TILE_WRITER_STATS_EN
  ,
  output logic [15:0]       write_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

  localparam int                CELLS     = COLS * ROWS;
  localparam int                ENTRY_W   = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_sweep_addr;
  logic                r_live;
  logic                w_in_range;
  logic                w_accept;
  logic                w_enq;
  logic                w_fifo_push;
  logic                w_fifo_pop;
  logic                w_full;
  logic                w_empty;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_code;
  logic [ENTRY_W-1:0]  w_fifo_dout;

  assign w_in_range = (int'(req_x) < COLS) && (int'(req_y) < ROWS);
  assign req_ready  = r_live && !w_full && (r_state == ST_IDLE);
  assign w_accept   = req_valid && req_ready;
  assign w_enq      = w_accept && w_in_range;
  assign w_addr     = ADDR_W'(req_y) * ADDR_W'(COLS) + ADDR_W'(req_x);
  assign w_code     = encode_tile(req_kind, style_e'(req_style));
  assign busy       = !w_empty || (r_state != ST_IDLE);

  // An accept into an empty FIFO bypasses storage so the write lands the next cycle.
  assign w_fifo_pop  = (r_state != ST_SWEEP) && !w_empty;
  assign w_fifo_push = w_enq && !w_empty;

  vram_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_din   ({w_addr, w_code}),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sweep_addr <= '0;
      r_live       <= 1'b0;
      vram_we      <= 1'b0;
      vram_addr    <= '0;
      vram_data    <= '0;
      clear_done   <= 1'b0;
      err_oob      <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      vram_we    <= 1'b0;
      clear_done <= 1'b0;
      err_oob    <= w_accept && !w_in_range;
      case (r_state)
        ST_IDLE: begin
          if (w_fifo_pop) begin
            vram_we                <= 1'b1;
            {vram_addr, vram_data} <= w_fifo_dout;
          end else if (w_enq) begin
            vram_we   <= 1'b1;
            vram_addr <= w_addr;
            vram_data <= w_code;
          end
          if (clear_req && r_live) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_fifo_pop) begin
            vram_we                <= 1'b1;
            {vram_addr, vram_data} <= w_fifo_dout;
          end else begin
            r_state      <= ST_SWEEP;
            r_sweep_addr <= '0;
          end
        end
        ST_SWEEP: begin
          vram_we   <= 1'b1;
          vram_addr <= r_sweep_addr;
          vram_data <= TILE_BG;
          if (r_sweep_addr == LAST_ADDR) begin
            clear_done <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_sweep_addr <= r_sweep_addr + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef VRAM_TILE_WRITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                              write_count <= '0;
    else if (vram_we && write_count != '1) write_count <= write_count + 1'b1;
  end
`endif

endmodule
